// File: rtl/ifetch_queue.sv
// ifetch_queue: issues sequential fetch PCs to the LSB, collects in-order returns and queues {ins, pc} for decode.
// Latency: ins_ready -> dec_valid 1 cycle; with IFQ_BYPASS_EN defined, 0 cycles when the queue is empty and nothing is dropping.
// Backpressure: issue is blocked by lsb_full and by credits (in-flight + queued < QDEPTH); dec_ready stalls pops; pause freezes all state.
module ifetch_queue #(
   parameter logic [31:0] RESET_PC = 32'h0,
   parameter int          QDEPTH   = 4,
   parameter int          MAX_OUT  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pause,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        lsb_full,
   output logic [31:0] pc_addr,
   output logic        new_ins,
   input  logic        ins_ready,
   input  logic [31:0] ins_value,
   output logic        dec_valid,
   output logic [31:0] dec_ins,
   output logic [31:0] dec_pc,
   input  logic        dec_ready
);

   localparam int QW = $clog2(QDEPTH + 1);
   localparam int PW = $clog2(QDEPTH);
   localparam int OW = $clog2(MAX_OUT + 1);

   typedef enum logic {ST_RUN, ST_FLUSH} state_t;

   state_t          r_state, w_state_nxt;
   logic [31:0]     r_pc, r_pc_addr;
   logic            r_new_ins;
   logic [OW-1:0]   r_out_cnt, r_drop_cnt, w_out_nxt, w_drop_nxt;
   logic [31:0]     r_q_ins [QDEPTH];
   logic [31:0]     r_q_pc  [QDEPTH];
   logic [PW-1:0]   r_q_rd, r_q_wr;
   logic [QW-1:0]   r_q_cnt;

   logic            w_issue, w_ret, w_drop, w_push, w_pop, w_byp, w_q_empty;
   logic [31:0]     w_tag;

   assign w_q_empty = (r_q_cnt == '0);

   // Fetches are sequential and return in order, so the oldest live fetch address is
   // pc minus the number still outstanding; this stands in for an explicit tag FIFO.
   // Dropped returns never count in out_cnt, so they never disturb this arithmetic.
   assign w_tag = r_pc - (32'(r_out_cnt) << 2);

`ifdef IFQ_BYPASS_EN
   assign w_byp = ins_ready && !pause && !redirect_valid && (r_drop_cnt == '0)
                  && w_q_empty && dec_ready;
`else
   assign w_byp = 1'b0;
`endif

   // Issue/return/pop qualification and next-state for FSM and counters
   always_comb begin
      w_state_nxt = r_state;
      w_out_nxt   = r_out_cnt;
      w_drop_nxt  = r_drop_cnt;
      w_drop      = ins_ready && (r_drop_cnt != '0);
      w_ret       = ins_ready && (r_drop_cnt == '0);
      w_issue     = (r_state == ST_RUN) && !redirect_valid && !lsb_full
                    && (int'(r_out_cnt) < MAX_OUT)
                    && (int'(r_out_cnt) + int'(r_q_cnt) < QDEPTH);
      w_push      = w_ret && !redirect_valid && !w_byp;
      w_pop       = !w_q_empty && dec_ready && !redirect_valid;
      if (redirect_valid) begin
         // Everything still in flight, minus a word landing now (itself discarded), must be dropped
         w_out_nxt   = '0;
         w_drop_nxt  = r_drop_cnt + r_out_cnt - OW'(ins_ready);
         w_state_nxt = (w_drop_nxt != '0) ? ST_FLUSH : ST_RUN;
      end else begin
         w_out_nxt  = r_out_cnt + OW'(w_issue) - OW'(w_ret);
         w_drop_nxt = r_drop_cnt - OW'(w_drop);
         if ((r_state == ST_FLUSH) && (w_drop_nxt == '0)) begin
            w_state_nxt = ST_RUN;
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_RUN;
      end else if (!pause) begin
         r_state <= w_state_nxt;
      end
   end

   // PC, fetch request and in-flight/drop counters
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pc       <= RESET_PC;
         r_pc_addr  <= '0;
         r_new_ins  <= 1'b0;
         r_out_cnt  <= '0;
         r_drop_cnt <= '0;
      end else if (!pause) begin
         r_new_ins  <= w_issue;
         r_out_cnt  <= w_out_nxt;
         r_drop_cnt <= w_drop_nxt;
         if (w_issue) begin
            r_pc_addr <= r_pc;
         end
         if (redirect_valid) begin
            r_pc <= redirect_pc;
         end else if (w_issue) begin
            r_pc <= r_pc + 32'd4;
         end
      end
   end

   // Decoder queue storage and pointers; storage is reset so dec_ins/dec_pc read zero after reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < QDEPTH; i++) begin
            r_q_ins[i] <= '0;
            r_q_pc[i]  <= '0;
         end
         r_q_rd  <= '0;
         r_q_wr  <= '0;
         r_q_cnt <= '0;
      end else if (!pause) begin
         if (redirect_valid) begin
            r_q_rd  <= '0;
            r_q_wr  <= '0;
            r_q_cnt <= '0;
         end else begin
            if (w_push) begin
               r_q_ins[r_q_wr] <= ins_value;
               r_q_pc[r_q_wr]  <= w_tag;
               r_q_wr          <= r_q_wr + PW'(1);
            end
            if (w_pop) begin
               r_q_rd <= r_q_rd + PW'(1);
            end
            r_q_cnt <= r_q_cnt + QW'(w_push) - QW'(w_pop);
         end
      end
   end

   // A pulse registered just before a stall is held and delivered once pause drops
   assign new_ins   = r_new_ins & ~pause;
   assign pc_addr   = r_pc_addr;
   assign dec_valid = !w_q_empty || w_byp;
   assign dec_ins   = w_byp ? ins_value : r_q_ins[r_q_rd];
   assign dec_pc    = w_byp ? w_tag     : r_q_pc[r_q_rd];

endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed scenarios plus randomized traffic against a queue-based reference model.
// Latency: bench drives inputs at negedge, samples outputs 1 time unit later.
// Backpressure: a bench-side LSB returns pending fetches in order at random; decoder readiness is random.
module tb_ifetch_queue;

   localparam logic [31:0] RESET_PC = 32'h100;
   localparam int          QDEPTH   = 4;
   localparam int          MAX_OUT  = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        pause, redirect_valid, lsb_full, ins_ready, dec_ready;
   logic [31:0] redirect_pc, ins_value;
   logic [31:0] pc_addr, dec_ins, dec_pc;
   logic        new_ins, dec_valid;

   ifetch_queue #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH), .MAX_OUT(MAX_OUT)) dut (
      .clk(clk), .rst(rst), .pause(pause), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .lsb_full(lsb_full), .pc_addr(pc_addr), .new_ins(new_ins),
      .ins_ready(ins_ready), .ins_value(ins_value), .dec_valid(dec_valid), .dec_ins(dec_ins),
      .dec_pc(dec_pc), .dec_ready(dec_ready)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: in-flight fetch addresses, decoder queue of {ins, pc}, drop count
   logic [31:0] m_pc, m_addr;
   bit          m_req, m_flush;
   int          m_drop;
   logic [31:0] m_inflight[$];
   logic [63:0] m_dq[$];
   logic [31:0] lsb_q[$];

   logic        obs_new_ins, obs_dv, exp_new_ins, exp_dv;
   logic [31:0] obs_pc_addr, obs_di, obs_dp, exp_pc_addr, exp_di, exp_dp;
   logic [31:0] words[4];

   task automatic model_init();
      m_pc = RESET_PC; m_addr = '0; m_req = 1'b0; m_flush = 1'b0; m_drop = 0;
      m_inflight.delete(); m_dq.delete(); lsb_q.delete();
   endtask

   task automatic set_idle_inputs();
      pause = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; lsb_full = 1'b0;
      ins_ready = 1'b0; ins_value = '0; dec_ready = 1'b1;
   endtask

   // One clock: drive at negedge, sample, feed the bench LSB and the model, end at next negedge
   task automatic step(input bit p, input bit rv, input logic [31:0] rpc, input bit full,
                       input bit want_ret, input logic [31:0] word, input bit drdy);
      bit          rdy, issue;
      int          ndrop;
      logic [31:0] tag;
      rdy = want_ret && (lsb_q.size() > 0);
      pause = p; redirect_valid = rv; redirect_pc = rpc; lsb_full = full;
      ins_ready = rdy; ins_value = rdy ? word : 32'h0; dec_ready = drdy;
      #1;
      obs_new_ins = new_ins; obs_pc_addr = pc_addr;
      obs_dv = dec_valid; obs_di = dec_ins; obs_dp = dec_pc;
      exp_new_ins = m_req && !p;
      exp_pc_addr = m_addr;
      exp_dv = (m_dq.size() > 0);
      exp_di = exp_dv ? m_dq[0][63:32] : 32'h0;
      exp_dp = exp_dv ? m_dq[0][31:0]  : 32'h0;
      if (obs_new_ins === 1'b1) lsb_q.push_back(obs_pc_addr);
      if (!p) begin
         if (rdy) void'(lsb_q.pop_front());
         issue = !m_flush && !rv && !full && (m_inflight.size() < MAX_OUT)
                 && (m_inflight.size() + m_dq.size() < QDEPTH);
         if (rv) begin
            ndrop = m_drop + m_inflight.size() - (rdy ? 1 : 0);
            m_inflight.delete(); m_dq.delete();
            m_pc = rpc; m_drop = ndrop; m_flush = (ndrop > 0); m_req = 1'b0;
         end else begin
            if ((m_dq.size() > 0) && drdy) void'(m_dq.pop_front());
            if (rdy) begin
               if (m_drop > 0) m_drop--;
               else if (m_inflight.size() > 0) begin
                  tag = m_inflight.pop_front();
                  m_dq.push_back({word, tag});
               end
            end
            if (m_flush && (m_drop == 0)) m_flush = 1'b0;
            m_req = issue;
            if (issue) begin
               m_addr = m_pc;
               m_inflight.push_back(m_pc);
               m_pc = m_pc + 32'd4;
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      set_idle_inputs();
      model_init();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      set_idle_inputs();
      model_init();
      #1;
      n_checks++; if (new_ins !== 1'b0) begin n_errors++; $display("FAIL reset_new_ins: got %b expected 0", new_ins); end
      n_checks++; if (pc_addr !== 32'h0) begin n_errors++; $display("FAIL reset_pc_addr: got %h expected 0", pc_addr); end
      n_checks++; if (dec_valid !== 1'b0) begin n_errors++; $display("FAIL reset_dec_valid: got %b expected 0", dec_valid); end
      n_checks++; if (dec_ins !== 32'h0) begin n_errors++; $display("FAIL reset_dec_ins: got %h expected 0", dec_ins); end
      n_checks++; if (dec_pc !== 32'h0) begin n_errors++; $display("FAIL reset_dec_pc: got %h expected 0", dec_pc); end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      idle();
      n_checks++; if (obs_new_ins !== 1'b0) begin n_errors++; $display("FAIL post_reset_new_ins: got %b expected 0", obs_new_ins); end
      n_checks++; if (obs_dv !== 1'b0) begin n_errors++; $display("FAIL post_reset_dec_valid: got %b expected 0", obs_dv); end
   endtask

   task automatic test_fill();
      do_reset();
      for (int i = 0; i < 7; i++) begin
         idle();
         n_checks++;
         if (obs_new_ins !== ((i >= 1) && (i <= 4))) begin
            n_errors++; $display("FAIL fill_new_ins[%0d]: got %b expected %b", i, obs_new_ins, (i >= 1) && (i <= 4));
         end
         if ((i >= 1) && (i <= 4)) begin
            n_checks++;
            if (obs_pc_addr !== RESET_PC + 32'(4 * (i - 1))) begin
               n_errors++; $display("FAIL fill_pc_addr[%0d]: got %h expected %h", i, obs_pc_addr, RESET_PC + 32'(4 * (i - 1)));
            end
         end
      end
   endtask

   task automatic test_return();
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h00000013, 1'b1);
      n_checks++; if (obs_dv !== 1'b0) begin n_errors++; $display("FAIL ret_dv_same_cycle: got %b expected 0", obs_dv); end
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h00100093, 1'b1);
      n_checks++; if (obs_dv !== 1'b1) begin n_errors++; $display("FAIL ret0_dv: got %b expected 1", obs_dv); end
      n_checks++; if (obs_dp !== 32'h100) begin n_errors++; $display("FAIL ret0_pc: got %h expected 100", obs_dp); end
      n_checks++; if (obs_di !== 32'h00000013) begin n_errors++; $display("FAIL ret0_ins: got %h expected 00000013", obs_di); end
      idle();
      n_checks++; if (obs_dv !== 1'b1) begin n_errors++; $display("FAIL ret1_dv: got %b expected 1", obs_dv); end
      n_checks++; if (obs_dp !== 32'h104) begin n_errors++; $display("FAIL ret1_pc: got %h expected 104", obs_dp); end
      n_checks++; if (obs_di !== 32'h00100093) begin n_errors++; $display("FAIL ret1_ins: got %h expected 00100093", obs_di); end
      idle();
      n_checks++; if (obs_dv !== 1'b0) begin n_errors++; $display("FAIL ret_drained_dv: got %b expected 0", obs_dv); end
      n_checks++; if (obs_new_ins !== 1'b1) begin n_errors++; $display("FAIL ret_reissue: got %b expected 1", obs_new_ins); end
      n_checks++; if (obs_pc_addr !== 32'h110) begin n_errors++; $display("FAIL ret_reissue_pc: got %h expected 110", obs_pc_addr); end
   endtask

   task automatic test_backpressure();
      do_reset();
      for (int i = 0; i < 5; i++) idle();
      for (int i = 0; i < 4; i++) begin
         words[i] = $urandom;
         step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, words[i], 1'b0);
         n_checks++; if (obs_new_ins !== 1'b0) begin n_errors++; $display("FAIL bp_ret_new_ins[%0d]: got %b expected 0", i, obs_new_ins); end
      end
      for (int i = 0; i < 2; i++) begin
         step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
         n_checks++; if (obs_new_ins !== 1'b0) begin n_errors++; $display("FAIL bp_full_new_ins[%0d]: got %b expected 0", i, obs_new_ins); end
         n_checks++; if (obs_dp !== 32'h100) begin n_errors++; $display("FAIL bp_full_head_pc[%0d]: got %h expected 100", i, obs_dp); end
         n_checks++; if (obs_di !== words[0]) begin n_errors++; $display("FAIL bp_full_head_ins[%0d]: got %h expected %h", i, obs_di, words[0]); end
      end
      idle();
      n_checks++; if (obs_dv !== 1'b1) begin n_errors++; $display("FAIL bp_pop_dv: got %b expected 1", obs_dv); end
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      n_checks++; if (obs_new_ins !== 1'b0) begin n_errors++; $display("FAIL bp_p1_new_ins: got %b expected 0", obs_new_ins); end
      n_checks++; if (obs_dp !== 32'h104) begin n_errors++; $display("FAIL bp_p1_head_pc: got %h expected 104", obs_dp); end
      n_checks++; if (obs_di !== words[1]) begin n_errors++; $display("FAIL bp_p1_head_ins: got %h expected %h", obs_di, words[1]); end
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      n_checks++; if (obs_new_ins !== 1'b1) begin n_errors++; $display("FAIL bp_one_issue: got %b expected 1", obs_new_ins); end
      n_checks++; if (obs_pc_addr !== 32'h110) begin n_errors++; $display("FAIL bp_one_issue_pc: got %h expected 110", obs_pc_addr); end
      for (int i = 0; i < 2; i++) begin
         step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
         n_checks++; if (obs_new_ins !== 1'b0) begin n_errors++; $display("FAIL bp_no_more_issue[%0d]: got %b expected 0", i, obs_new_ins); end
      end
   endtask

   task automatic test_redirect();
      do_reset();
      for (int i = 0; i < 5; i++) idle();
      step(1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, $urandom, 1'b1);
         n_checks++; if (obs_dv !== 1'b0) begin n_errors++; $display("FAIL redir_drop_dv[%0d]: got %b expected 0", i, obs_dv); end
         n_checks++; if (obs_new_ins !== 1'b0) begin n_errors++; $display("FAIL redir_drop_new_ins[%0d]: got %b expected 0", i, obs_new_ins); end
      end
      idle();
      n_checks++; if (obs_new_ins !== 1'b0) begin n_errors++; $display("FAIL redir_x1_new_ins: got %b expected 0", obs_new_ins); end
      n_checks++; if (obs_dv !== 1'b0) begin n_errors++; $display("FAIL redir_x1_dv: got %b expected 0", obs_dv); end
      idle();
      n_checks++; if (obs_new_ins !== 1'b1) begin n_errors++; $display("FAIL redir_first_issue: got %b expected 1", obs_new_ins); end
      n_checks++; if (obs_pc_addr !== 32'h200) begin n_errors++; $display("FAIL redir_first_pc: got %h expected 200", obs_pc_addr); end
      idle();
      n_checks++; if (obs_pc_addr !== 32'h204) begin n_errors++; $display("FAIL redir_second_pc: got %h expected 204", obs_pc_addr); end
   endtask

   task automatic test_stall();
      do_reset();
      idle();
      idle();
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
         n_checks++; if (obs_new_ins !== (i == 0)) begin n_errors++; $display("FAIL full_new_ins[%0d]: got %b expected %b", i, obs_new_ins, i == 0); end
      end
      idle();
      n_checks++; if (obs_new_ins !== 1'b0) begin n_errors++; $display("FAIL full_release_new_ins: got %b expected 0", obs_new_ins); end
      idle();
      n_checks++; if (obs_new_ins !== 1'b1) begin n_errors++; $display("FAIL full_resume: got %b expected 1", obs_new_ins); end
      n_checks++; if (obs_pc_addr !== 32'h108) begin n_errors++; $display("FAIL full_resume_pc: got %h expected 108", obs_pc_addr); end
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hCAFE0001, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hBAD00000, 1'b1);
         n_checks++; if (obs_new_ins !== 1'b0) begin n_errors++; $display("FAIL pause_new_ins[%0d]: got %b expected 0", i, obs_new_ins); end
         n_checks++; if (obs_dv !== 1'b1) begin n_errors++; $display("FAIL pause_dv_hold[%0d]: got %b expected 1", i, obs_dv); end
         n_checks++; if (obs_dp !== 32'h100) begin n_errors++; $display("FAIL pause_dp_hold[%0d]: got %h expected 100", i, obs_dp); end
      end
      idle();
      n_checks++; if (obs_di !== 32'hCAFE0001) begin n_errors++; $display("FAIL pause_release_ins: got %h expected cafe0001", obs_di); end
      idle();
      n_checks++; if (obs_dv !== 1'b0) begin n_errors++; $display("FAIL pause_ignored_return: got %b expected 0", obs_dv); end
      idle();
      n_checks++; if (obs_new_ins !== 1'b1) begin n_errors++; $display("FAIL pause_resume: got %b expected 1", obs_new_ins); end
      n_checks++; if (obs_pc_addr !== 32'h110) begin n_errors++; $display("FAIL pause_resume_pc: got %h expected 110", obs_pc_addr); end
   endtask

   task automatic test_reset_midflush();
      do_reset();
      for (int i = 0; i < 5; i++) idle();
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD0001, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD0002, 1'b0);
      step(1'b0, 1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h12345678, 1'b1);
      rst = 1'b0;
      set_idle_inputs();
      model_init();
      #1;
      n_checks++; if (new_ins !== 1'b0) begin n_errors++; $display("FAIL midrst_new_ins: got %b expected 0", new_ins); end
      n_checks++; if (pc_addr !== 32'h0) begin n_errors++; $display("FAIL midrst_pc_addr: got %h expected 0", pc_addr); end
      n_checks++; if (dec_valid !== 1'b0) begin n_errors++; $display("FAIL midrst_dec_valid: got %b expected 0", dec_valid); end
      n_checks++; if (dec_ins !== 32'h0) begin n_errors++; $display("FAIL midrst_dec_ins: got %h expected 0", dec_ins); end
      n_checks++; if (dec_pc !== 32'h0) begin n_errors++; $display("FAIL midrst_dec_pc: got %h expected 0", dec_pc); end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      idle();
      idle();
      n_checks++; if (obs_new_ins !== 1'b1) begin n_errors++; $display("FAIL midrst_first_issue: got %b expected 1", obs_new_ins); end
      n_checks++; if (obs_pc_addr !== RESET_PC) begin n_errors++; $display("FAIL midrst_first_pc: got %h expected %h", obs_pc_addr, RESET_PC); end
   endtask

   task automatic test_random();
      bit          p, rv, full, ret, drdy;
      logic [31:0] rpc;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         p    = ($urandom_range(15) == 0);
         rv   = ($urandom_range(19) == 0);
         rpc  = ($urandom_range(3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
         full = ($urandom_range(3) == 0);
         ret  = ($urandom_range(1) == 0);
         drdy = ($urandom_range(3) != 0);
         step(p, rv, rpc, full, ret, $urandom, drdy);
         n_checks++; if (obs_new_ins !== exp_new_ins) begin n_errors++; $display("FAIL rnd_new_ins[%0d]: got %b expected %b", i, obs_new_ins, exp_new_ins); end
         n_checks++; if (obs_pc_addr !== exp_pc_addr) begin n_errors++; $display("FAIL rnd_pc_addr[%0d]: got %h expected %h", i, obs_pc_addr, exp_pc_addr); end
         n_checks++; if (obs_dv !== exp_dv) begin n_errors++; $display("FAIL rnd_dec_valid[%0d]: got %b expected %b", i, obs_dv, exp_dv); end
         if (exp_dv) begin
            n_checks++; if (obs_di !== exp_di) begin n_errors++; $display("FAIL rnd_dec_ins[%0d]: got %h expected %h", i, obs_di, exp_di); end
            n_checks++; if (obs_dp !== exp_dp) begin n_errors++; $display("FAIL rnd_dec_pc[%0d]: got %h expected %h", i, obs_dp, exp_dp); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_return();
      test_backpressure();
      test_redirect();
      test_stall();
      test_reset_midflush();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
